ps2_cmd_ctrl: RTL and testbench

Host-to-device command controller for the PS/2 keyboard port. It sends a one- or two-byte command to the keyboard, for example 0xED followed by an LED mask, over the shared open-drain ps2_clk/ps2_dat lines. It then waits for the keyboard's 0xFA acknowledge, which the existing PS/2 byte receiver delivers back to it. The block sits beside that receiver on the same pins and blanks it while the host owns the bus.

---
 rtl/ps2_cmd_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host-to-device command sender: inhibits the bus, shifts out one or two
// bytes on device-generated clocks, checks the ack bit and waits for 0xFA.
module ps2_cmd_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        ps2_clk,
  inout  wire        ps2_dat,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic       req_has_arg,
  input  logic [7:0] req_arg,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       rx_block,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INH   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_TX    = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;

  localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    k_q, k_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    cmd_q, cmd_d, arg_q, arg_d;
  logic          has_arg_q, has_arg_d, sel_arg_q, sel_arg_d;
  logic          clk_low_q, clk_low_d, dat_low_q, dat_low_d;
  logic          done_q, done_d, err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;

  logic [7:0] cur;
  logic       fall, tmo, dat_tx_d, resend;
  logic [1:0] rs_code;

  assign cur  = sel_arg_q ? arg_q : cmd_q;
  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign tmo  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    retry_d    = retry_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    sel_arg_d  = sel_arg_q;
    dat_tx_d   = dat_low_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    resend     = 1'b0;
    rs_code    = 2'b10;
    case (state_q)
      S_IDLE: if (req_valid) begin
        cmd_d      = req_cmd;
        arg_d      = req_arg;
        has_arg_d  = req_has_arg;
        sel_arg_d  = 1'b0;
        retry_d    = '0;
        err_code_d = 2'b00;
        state_d    = S_INH;
      end
      S_INH:   if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = S_START;
      S_START: begin
        k_d     = 4'd0;
        state_d = S_TX;
      end
      S_TX: if (fall) begin
        // dat_low is the inverse of the bit on the wire: 1 means pull low
        k_d = k_q + 4'd1;
        if (k_q < 4'd8)       dat_tx_d = ~cur[k_q[2:0]];
        else if (k_q == 4'd8) dat_tx_d = ^cur;
        else begin
          dat_tx_d = 1'b0;
          state_d  = S_ACK;
        end
      end else if (tmo) resend = 1'b1;
      S_ACK: if (fall) begin
        if (!dat_sync_q[1]) state_d = S_WAIT;
        else begin
          err_d      = 1'b1;
          err_code_d = 2'b01;
          state_d    = S_IDLE;
        end
      end else if (tmo) resend = 1'b1;
      S_WAIT: begin
        // a valid 0xFA/0xFE wins over a coincident timeout
        if (rx_valid && rx_byte == 8'hFA) state_d = S_NEXT;
        else if (rx_valid && rx_byte == 8'hFE) begin
          resend  = 1'b1;
          rs_code = 2'b11;
        end else if (tmo) resend = 1'b1;
      end
      S_NEXT: if (has_arg_q && !sel_arg_q) begin
        sel_arg_d = 1'b1;
        retry_d   = '0;
        state_d   = S_INH;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (resend) begin
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + 1'b1;
        state_d = S_INH;
      end else begin
        err_d      = 1'b1;
        err_code_d = rs_code;
        state_d    = S_IDLE;
      end
    end
    cnt_d     = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
    clk_low_d = (state_d == S_INH);
    dat_low_d = (state_d == S_INH && cnt_d == CW'(INHIBIT_CYCLES - 1)) ||
                (state_d == S_START) || (state_d == S_TX && dat_tx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      retry_q    <= '0;
      cmd_q      <= '0;
      arg_q      <= '0;
      has_arg_q  <= 1'b0;
      sel_arg_q  <= 1'b0;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      retry_q    <= retry_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      has_arg_q  <= has_arg_d;
      sel_arg_q  <= sel_arg_d;
      clk_low_q  <= clk_low_d;
      dat_low_q  <= dat_low_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign ps2_clk   = clk_low_q ? 1'b0 : 1'bz;
  assign ps2_dat   = dat_low_q ? 1'b0 : 1'bz;
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rx_block  = (state_q == S_INH) || (state_q == S_START) ||
                     (state_q == S_TX)  || (state_q == S_ACK);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Bench for ps2_cmd_ctrl: a PS/2 keyboard model clocks frames out of the DUT,
// a vector table drives requests and a scoreboard checks frames and completions.
module tb_ps2_cmd_ctrl;
  localparam int INH = 20;
  localparam int TMO = 400;
  localparam int MR  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wire ps2_clk, ps2_dat;
  pullup (ps2_clk);
  pullup (ps2_dat);
  logic dev_clk_low = 1'b0, dev_dat_low = 1'b0;
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  logic       req_valid = 1'b0, req_has_arg = 1'b0, rx_valid = 1'b0;
  logic [7:0] req_cmd = '0, req_arg = '0, rx_byte = '0;
  logic       req_ready, rx_block, busy, done, err;
  logic [1:0] err_code;

  ps2_cmd_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_has_arg(req_has_arg), .req_arg(req_arg), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .rx_block(rx_block), .busy(busy), .done(done),
    .err(err), .err_code(err_code));

  typedef struct {
    string      name;
    logic [7:0] cmd;
    logic       has_arg;
    logic [7:0] arg;
    int         n_cmd;     // frames of the command byte the device sees
    int         n_fe;      // 0xFE replies before 0xFA on the command byte
    bit         ack_ok;
    bit         clocks;    // 0: device never clocks after START
    logic       exp_done;
    logic [1:0] exp_code;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_frames[$];
  logic [2:0] res_q[$];
  logic [2:0] mon_e;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired before the expected event", nm);
  endtask

  function automatic vec_t mk(input string nm, input logic [7:0] c, input logic ha,
                              input logic [7:0] a, input int nc, input int nf,
                              input bit ak, input bit ck, input logic ed, input logic [1:0] ec);
    vec_t v;
    v.name = nm; v.cmd = c; v.has_arg = ha; v.arg = a; v.n_cmd = nc; v.n_fe = nf;
    v.ack_ok = ak; v.clocks = ck; v.exp_done = ed; v.exp_code = ec;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      if (res_q.size() == 0) chk("unexpected_completion", {29'd0, done, err, err_code}, 32'd0);
      else begin
        mon_e = res_q.pop_front();
        chk("completion", {29'd0, done, err, err_code}, {29'd0, mon_e[2], ~mon_e[2], mon_e[1:0]});
      end
    end
  end

  task automatic wait_clk(input logic lvl, input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (ps2_clk === lvl) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    bound_fail(nm);
  endtask

  // Inhibit phase: measure the host's clock-low time and check the start bit.
  task automatic dev_inhibit();
    bit ok;
    int lowcnt;
    wait_clk(1'b0, "inhibit_start", ok);
    if (!ok) return;
    lowcnt = 0;
    while (ps2_clk === 1'b0 && lowcnt < 3000) begin
      lowcnt++;
      @(negedge clk);
    end
    chk("inhibit_len", lowcnt, INH);
    chk("start_bit", {31'd0, ps2_dat}, 32'd0);
    chk("rx_block_frame", {31'd0, rx_block}, 32'd1);
  endtask

  task automatic dev_clock_one();
    dev_clk_low = 1'b1;
    repeat (10) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic dev_frame(input bit do_ack);
    logic [10:1] bits;
    logic [7:0]  e;
    dev_inhibit();
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clock_one();
      bits[i] = ps2_dat;
      repeat (5) @(negedge clk);
    end
    if (exp_frames.size() == 0) chk("unexpected_frame", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
    else begin
      e = exp_frames.pop_front();
      chk("frame_data", {24'd0, bits[8:1]}, {24'd0, e});
      chk("frame_parity", {31'd0, bits[9]}, {31'd0, ~^e});
    end
    chk("frame_stop", {31'd0, bits[10]}, 32'd1);
    dev_dat_low = do_ack;
    repeat (2) @(negedge clk);
    dev_clock_one();
    dev_dat_low = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    repeat (6) @(negedge clk);
    chk("rx_block_wait", {31'd0, rx_block}, 32'd0);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Accept, then keep req_valid high with different contents while busy.
  task automatic drive_req(input logic [7:0] c, input logic ha, input logic [7:0] a);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_cmd = c; req_has_arg = ha; req_arg = a;
    @(negedge clk);
    chk("busy_after_accept", {30'd0, busy, req_ready}, 32'd2);
    req_cmd = 8'h55; req_has_arg = 1'b0; req_arg = 8'hAA;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (res_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      bound_fail(nm);
      res_q.delete();
    end
    @(negedge clk);
    chk("ready_after_end", {30'd0, req_ready, busy}, 32'd2);
  endtask

  task automatic run_vec(input vec_t v);
    for (int j = 0; j < v.n_cmd; j++) exp_frames.push_back(v.cmd);
    if (v.has_arg) exp_frames.push_back(v.arg);
    res_q.push_back({v.exp_done, v.exp_code});
    fork
      drive_req(v.cmd, v.has_arg, v.arg);
      begin
        if (!v.clocks) begin
          for (int t = 0; t <= MR; t++) dev_inhibit();
        end else begin
          for (int j = 0; j < v.n_cmd; j++) begin
            dev_frame(v.ack_ok);
            if (v.ack_ok) send_rx((j < v.n_fe) ? 8'hFE : 8'hFA);
          end
          if (v.has_arg) begin
            dev_frame(1'b1);
            send_rx(8'hFA);
          end
        end
      end
    join
    wait_done(v.name);
    chk("frames_left", exp_frames.size(), 32'd0);
    exp_frames.delete();
    chk("pins_released", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    chk("err_code_hold", {30'd0, err_code}, {30'd0, v.exp_code});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vecs[0] = mk("single_f4",   8'hF4, 1'b0, 8'h00, 1, 0, 1'b1, 1'b1, 1'b1, 2'b00);
    vecs[1] = mk("ed_07",       8'hED, 1'b1, 8'h07, 1, 0, 1'b1, 1'b1, 1'b1, 2'b00);
    vecs[2] = mk("fe_twice",    8'hED, 1'b0, 8'h00, 3, 2, 1'b1, 1'b1, 1'b1, 2'b00);
    vecs[3] = mk("fe_limit",    8'hED, 1'b0, 8'h00, 3, 3, 1'b1, 1'b1, 1'b0, 2'b11);
    vecs[4] = mk("no_ack_bit",  8'hF4, 1'b0, 8'h00, 1, 0, 1'b0, 1'b1, 1'b0, 2'b01);
    vecs[5] = mk("timeout",     8'hF4, 1'b0, 8'h00, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10);

    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, req_ready, busy, done, err, err_code}, {26'd0, 6'b10_0000});
    chk("reset_rx_block", {31'd0, rx_block}, 32'd0);
    chk("reset_pins", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of a frame, after four data bits of 0xF4.
    fork
      begin
        req_valid = 1'b1; req_cmd = 8'hF4; req_has_arg = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
      end
      begin
        wait_clk(1'b0, "rst_inhibit", ok);
        wait_clk(1'b1, "rst_start", ok);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          dev_clock_one();
          repeat (5) @(negedge clk);
        end
      end
    join
    chk("mid_frame_dat_low", {31'd0, ps2_dat}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_pins", {30'd0, ps2_clk, ps2_dat}, 32'd3);
    chk("rst_outputs", {25'd0, req_ready, busy, done, err, err_code, rx_block}, {25'd0, 7'b1000000});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0]);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
